ct_spsram_128x16_ctrl: RTL and testbench

CT_SPSRAM_128X16_CTRL -- requirements
Module: ct_spsram_128x16_ctrl

---
 rtl/ct_spsram_128x16_ctrl_pkg.sv | 13 +
 rtl/ct_spsram_128x16_ctrl.sv | 95 +++++++++
 tb/tb_ct_spsram_128x16_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ct_spsram_128x16_ctrl_pkg.sv
// Shared sizes and FSM encoding for the 128x16 single-port SRAM controller.
package ct_spsram_128x16_ctrl_pkg;

  localparam int ADDR_WIDTH = 7;
  localparam int DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    INIT = 2'd1,
    IDLE = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/ct_spsram_128x16_ctrl.sv
// Front-end controller for a 128x16 single-port SRAM: power-up/explicit clear
// sweep, single-cycle masked writes and reads with a one-cycle response.
module ct_spsram_128x16_ctrl
  import ct_spsram_128x16_ctrl_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] INIT_VAL = 16'h0000
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  req_vld,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_bmask,
  output logic                  req_rdy,
  output logic                  rsp_vld,
  output logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  init_start,
  output logic                  init_busy,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  ctrl_state_e           state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] hold;
  logic                  accept;

  // init_start wins over a concurrent request so the sweep never races an access
  assign req_rdy   = (state == IDLE) && !init_start;
  assign init_busy = (state != IDLE);
  assign accept    = req_vld && req_rdy;
  assign rsp_data  = rsp_vld ? sram_q : hold;

  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    if (state == INIT) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = cnt;
      sram_d    = INIT_VAL;
    end else if (accept) begin
      sram_cen = 1'b0;
      sram_a   = req_addr;
      if (req_wr) begin
        sram_gwen = 1'b0;
        sram_wen  = ~req_bmask;
        sram_d    = req_wdata;
      end
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state   <= BOOT;
      cnt     <= '0;
      rsp_vld <= 1'b0;
      hold    <= '0;
    end else begin
      rsp_vld <= accept && !req_wr;
      if (rsp_vld) hold <= sram_q;
      case (state)
        BOOT: begin
          state <= INIT;
          cnt   <= '0;
        end
        INIT: begin
          // cnt wraps to 0 naturally on the last entry
          cnt <= cnt + 7'd1;
          if (cnt == 7'd127) state <= IDLE;
        end
        IDLE: begin
          if (init_start) begin
            state <= INIT;
            cnt   <= '0;
          end
        end
        default: begin
          state <= BOOT;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ct_spsram_128x16_ctrl.sv
// Scoreboard bench for ct_spsram_128x16_ctrl with a behavioural bit-masked SRAM.
module tb_ct_spsram_128x16_ctrl;

  localparam logic [15:0] INIT_V = 16'h0000;

  logic        clk = 1'b0;
  logic        cpurst_b;
  logic        req_vld, req_wr, init_start;
  logic [6:0]  req_addr;
  logic [15:0] req_wdata, req_bmask;
  logic        req_rdy, rsp_vld, init_busy;
  logic [15:0] rsp_data;
  logic        sram_cen, sram_gwen;
  logic [15:0] sram_wen, sram_d, sram_q;
  logic [6:0]  sram_a;

  logic [15:0] mem [0:127];
  logic [15:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ct_spsram_128x16_ctrl #(.INIT_VAL(INIT_V)) dut (
    .forever_cpuclk(clk),
    .cpurst_b      (cpurst_b),
    .req_vld       (req_vld),
    .req_wr        (req_wr),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_bmask     (req_bmask),
    .req_rdy       (req_rdy),
    .rsp_vld       (rsp_vld),
    .rsp_data      (rsp_data),
    .init_start    (init_start),
    .init_busy     (init_busy),
    .sram_cen      (sram_cen),
    .sram_gwen     (sram_gwen),
    .sram_wen      (sram_wen),
    .sram_a        (sram_a),
    .sram_d        (sram_d),
    .sram_q        (sram_q)
  );

  // Behavioural SRAM: active-low enables, per-bit write mask, one-cycle read
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'hDEAD;
    sram_q = 16'h0000;
  end

  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q      <= mem[sram_a];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every response cycle must match the oldest outstanding read
  always @(negedge clk) begin
    if (rsp_vld) begin
      if (exp_q.size() == 0) check("spurious_rsp_vld", 64'(rsp_vld), 64'd0);
      else check("rsp_data", 64'(rsp_data), 64'(exp_q.pop_front()));
    end
  end

  task automatic do_write(input logic [6:0] a, input logic [15:0] d, input logic [15:0] m);
    req_vld = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d; req_bmask = m;
    @(negedge clk);
    check("wr_port", 64'({req_rdy, sram_cen, sram_gwen, sram_wen, sram_a, sram_d}),
          64'({1'b1, 1'b0, 1'b0, ~m, a, d}));
    @(posedge clk); #1;
    req_vld = 1'b0; req_wr = 1'b0;
  endtask

  task automatic do_read(input logic [6:0] a, input logic [15:0] expv);
    exp_q.push_back(expv);
    req_vld = 1'b1; req_wr = 1'b0; req_addr = a;
    @(negedge clk);
    check("rd_port", 64'({req_rdy, sram_cen, sram_gwen, sram_wen, sram_a}),
          64'({1'b1, 1'b0, 1'b1, 16'hFFFF, a}));
    @(posedge clk); #1;
    req_vld = 1'b0;
  endtask

  task automatic idle_cyc();
    @(negedge clk);
    check("idle_port", 64'({sram_cen, sram_gwen, sram_wen, sram_a, sram_d}),
          64'({1'b1, 1'b1, 16'hFFFF, 7'd0, 16'd0}));
    @(posedge clk); #1;
  endtask

  task automatic check_hold(input logic [15:0] v);
    @(negedge clk);
    check("hold", 64'({rsp_vld, rsp_data}), 64'({1'b0, v}));
    @(posedge clk); #1;
  endtask

  task automatic boot_cycle();
    @(negedge clk);
    check("boot", 64'({sram_cen, req_rdy, init_busy}), 64'({1'b1, 1'b0, 1'b1}));
    @(posedge clk); #1;
  endtask

  // 128 sweep cycles starting now; optional ignored init_start pulse at glitch_at
  task automatic sweep_check(input int glitch_at);
    logic [6:0] ai;
    int errs;
    errs = 0;
    for (int i = 0; i < 128; i++) begin
      ai = 7'(i);
      if (i == glitch_at) init_start = 1'b1;
      @(negedge clk);
      if ({sram_cen, sram_gwen, sram_wen, sram_a, sram_d, init_busy, req_rdy} !==
          {1'b0, 1'b0, 16'h0000, ai, INIT_V, 1'b1, 1'b0}) begin
        errs++;
        if (errs == 1)
          $display("FAIL sweep_cycle_%0d: a=%0d cen=%b wen=%h d=%h busy=%b expected a=%0d",
                   i, sram_a, sram_cen, sram_wen, sram_d, init_busy, ai);
      end
      @(posedge clk); #1;
      init_start = 1'b0;
    end
    total++;
    if (errs != 0) bad++;
    @(negedge clk);
    check("sweep_end", 64'({init_busy, req_rdy}), 64'({1'b0, 1'b1}));
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cpurst_b = 1'b0; req_vld = 1'b0; req_wr = 1'b0; init_start = 1'b0;
    req_addr = '0; req_wdata = '0; req_bmask = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'({sram_cen, req_rdy, init_busy, rsp_vld, rsp_data}),
          64'({1'b1, 1'b0, 1'b1, 1'b0, 16'h0000}));
    @(posedge clk); #1;
    cpurst_b = 1'b1;
    boot_cycle();
    sweep_check(-1);

    for (int i = 0; i < 128; i++) do_read(7'(i), INIT_V);
    idle_cyc();

    do_write(7'd7, 16'hA5A5, 16'hFFFF);
    do_read(7'd7, 16'hA5A5);
    idle_cyc();
    check_hold(16'hA5A5);

    do_write(7'd3, 16'hFFFF, 16'hFFFF);
    do_write(7'd3, 16'h0000, 16'h00FF);
    do_read(7'd3, 16'hFF00);
    idle_cyc();
    check_hold(16'hFF00);

    do_write(7'd1, 16'h0011, 16'hFFFF);
    do_write(7'd2, 16'h0022, 16'hFFFF);
    do_read(7'd1, 16'h0011);
    do_read(7'd2, 16'h0022);
    do_read(7'd3, 16'hFF00);
    idle_cyc();

    // Read in flight while init_start arrives still returns its data
    do_write(7'd5, 16'h1234, 16'hFFFF);
    do_read(7'd5, 16'h1234);
    init_start = 1'b1;
    @(negedge clk);
    check("rsp_across_init", 64'({rsp_vld, req_rdy}), 64'({1'b1, 1'b0}));
    @(posedge clk); #1;
    init_start = 1'b0;
    sweep_check(-1);
    check("queue_after_init", 64'(exp_q.size()), 64'd0);

    // Concurrent init_start and request: request refused, no access, restart ignored
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 7'd3; init_start = 1'b1;
    @(negedge clk);
    check("init_start_block", 64'({req_rdy, sram_cen, init_busy}), 64'({1'b0, 1'b1, 1'b0}));
    @(posedge clk); #1;
    req_vld = 1'b0; init_start = 1'b0;
    sweep_check(10);
    do_read(7'd3, INIT_V);
    do_read(7'd7, INIT_V);
    idle_cyc();

    // Reset mid-sweep at cnt=50 aborts and restarts a full sweep
    init_start = 1'b1;
    @(posedge clk); #1;
    init_start = 1'b0;
    repeat (50) begin @(posedge clk); #1; end
    @(negedge clk);
    check("mid_init_addr", 64'(sram_a), 64'd50);
    cpurst_b = 1'b0;
    #1;
    check("mid_init_reset", 64'({sram_cen, req_rdy, init_busy, rsp_vld}),
          64'({1'b1, 1'b0, 1'b1, 1'b0}));
    @(posedge clk); #1;
    cpurst_b = 1'b1;
    boot_cycle();
    sweep_check(-1);
    do_read(7'd5, INIT_V);
    idle_cyc();
    check("queue_final", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
